// File: rtl/tnn_feature_loader.sv
// rtl/tnn_feature_loader.sv - raw sample quantizer, frame packer and result returner for a 7-feature TNN core
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready    raw sample stream handshake
//   s_data, s_last     raw unsigned sample, end-of-frame marker
//   feat_vec           packed 2-bit codes, feature i at [2i+1:2i], drives the classifier
//   cls_in             classifier decision, combinational from feat_vec
//   m_valid/m_ready    result handshake
//   m_class, m_err     decision bit, malformed-frame flag
//   stat_frames/stat_pos/stat_err  saturating result counters (only with TNN_LOADER_STATS_EN)
//
// Optional feature macro: TNN_LOADER_STATS_EN

module tnn_feature_loader #(
    parameter int N_FEAT   = 7,
    parameter int RAW_W    = 8,
    parameter int THR0     = 64,
    parameter int THR1     = 128,
    parameter int THR2     = 192,
    parameter int EVAL_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [RAW_W-1:0]    s_data,
    input  logic                s_last,
    output logic [2*N_FEAT-1:0] feat_vec,
    input  logic                cls_in,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_class,
    output logic                m_err
`ifdef TNN_LOADER_STATS_EN
    ,
    output logic [15:0]         stat_frames,
    output logic [15:0]         stat_pos,
    output logic [15:0]         stat_err
`endif
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [3:0]       CNT_END  = 4'(EVAL_LAT - 1);

    generate
        if (!(THR0 < THR1 && THR1 < THR2)) begin : g_bad_thr
            $error("tnn_feature_loader: thresholds must satisfy THR0 < THR1 < THR2");
        end
        if (EVAL_LAT < 1 || EVAL_LAT > 15) begin : g_bad_lat
            $error("tnn_feature_loader: EVAL_LAT must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {ST_COLLECT, ST_DRAIN, ST_EVAL, ST_HOLD} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_live;      // keeps s_ready low for the reset-release cycle
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_cnt;
    logic                  r_err;
    logic [2*N_FEAT-1:0]   r_feat;
    logic                  r_m_valid;
    logic                  r_m_class;
    logic                  r_m_err;
    logic                  w_accept;
    logic                  w_done;
    logic [1:0]            w_code;

    assign w_accept = s_valid && s_ready;
    assign w_done   = r_m_valid && m_ready;

    always_comb begin
        w_code = 2'd3;
        if (int'(s_data) < THR0)      w_code = 2'd0;
        else if (int'(s_data) < THR1) w_code = 2'd1;
        else if (int'(s_data) < THR2) w_code = 2'd2;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_COLLECT;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_COLLECT: if (w_accept) begin
                if (r_idx == LAST_IDX) w_next = s_last ? ST_EVAL : ST_DRAIN;
                else if (s_last)       w_next = ST_EVAL;
            end
            ST_DRAIN:   if (w_accept && s_last) w_next = ST_EVAL;
            ST_EVAL:    if (r_cnt == CNT_END)   w_next = ST_HOLD;
            ST_HOLD:    if (w_done)             w_next = ST_COLLECT;
            default:    w_next = ST_COLLECT;
        endcase
    end

    // Output logic
    always_comb begin
        s_ready = r_live && (r_state == ST_COLLECT || r_state == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_feat    <= '0;
            r_m_valid <= 1'b0;
            r_m_class <= 1'b0;
            r_m_err   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_COLLECT: if (w_accept) begin
                    r_cnt <= '0;
                    // Current slot takes the code; on an early end the slots
                    // after it are cleared so no stale codes reach the core.
                    for (int i = 0; i < N_FEAT; i++) begin
                        if (i == int'(r_idx))
                            r_feat[2*i +: 2] <= w_code;
                        else if (s_last && i > int'(r_idx))
                            r_feat[2*i +: 2] <= 2'd0;
                    end
                    if (r_idx == LAST_IDX) r_err <= !s_last;
                    else if (s_last)       r_err <= 1'b1;
                    else                   r_idx <= r_idx + 1'b1;
                end
                ST_EVAL: begin
                    if (r_cnt == CNT_END) begin
                        r_m_class <= cls_in;
                        r_m_err   <= r_err;
                        r_m_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: if (w_done) begin
                    r_m_valid <= 1'b0;
                    r_idx     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign feat_vec = r_feat;
    assign m_valid  = r_m_valid;
    assign m_class  = r_m_class;
    assign m_err    = r_m_err;

`ifdef TNN_LOADER_STATS_EN
    logic [15:0] r_stat_frames;
    logic [15:0] r_stat_pos;
    logic [15:0] r_stat_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_frames <= '0;
            r_stat_pos    <= '0;
            r_stat_err    <= '0;
        end else if (w_done) begin
            if (r_stat_frames != 16'hFFFF)           r_stat_frames <= r_stat_frames + 1'b1;
            if (r_m_class && r_stat_pos != 16'hFFFF) r_stat_pos    <= r_stat_pos + 1'b1;
            if (r_m_err && r_stat_err != 16'hFFFF)   r_stat_err    <= r_stat_err + 1'b1;
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_pos    = r_stat_pos;
    assign stat_err    = r_stat_err;
`endif

endmodule

// File: tb/tb_tnn_feature_loader.sv
// tb/tb_tnn_feature_loader.sv - directed table-driven bench for tnn_feature_loader

module tb_tnn_feature_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic [13:0] feat_vec;
    logic        cls_in;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_class;
    logic        m_err;
`ifdef TNN_LOADER_STATS_EN
    logic [15:0] stat_frames, stat_pos, stat_err;
`endif

    int checks = 0;
    int failures = 0;
    int exp_frames = 0, exp_pos = 0, exp_err = 0;

    tnn_feature_loader dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .feat_vec(feat_vec), .cls_in(cls_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_err(m_err)
`ifdef TNN_LOADER_STATS_EN
        , .stat_frames(stat_frames), .stat_pos(stat_pos), .stat_err(stat_err)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in classifier: positive when the sum of the seven codes is at least 8.
    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < 7; i++) s += int'(feat_vec[2*i +: 2]);
        cls_in = (s >= 8);
    end

    typedef struct packed {
        logic [8:0][7:0] raw;
        int              n;
        logic [13:0]     fv;
        logic            cls;
        logic            err;
        int              hold;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input int n, input logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7, r8,
                                input logic [13:0] fv, input logic cls, err, input int hold);
        vec_t v;
        v.raw[0] = r0; v.raw[1] = r1; v.raw[2] = r2; v.raw[3] = r3; v.raw[4] = r4;
        v.raw[5] = r5; v.raw[6] = r6; v.raw[7] = r7; v.raw[8] = r8;
        v.n = n; v.fv = fv; v.cls = cls; v.err = err; v.hold = hold;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_beats(input vec_t v, input int count, input logic use_last);
        for (int b = 0; b < count; b++) begin
            int w;
            s_valid = 1'b1;
            s_data  = v.raw[b];
            s_last  = use_last && (b == v.n - 1);
            w = 0;
            while (!s_ready && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 50) chk("s_ready_timeout", 32'(s_ready), 32'd1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_vector(input int k, input vec_t v);
        int    lat;
        logic  stable;
        string tag;
        tag = $sformatf("v%0d", k);
        send_beats(v, v.n, 1'b1);
        lat = 0;
        while (!m_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd1);
        chk({tag, "_feat_vec"}, 32'(feat_vec), 32'(v.fv));
        chk({tag, "_m_class"}, 32'(m_class), 32'(v.cls));
        chk({tag, "_m_err"}, 32'(m_err), 32'(v.err));
        chk({tag, "_s_ready_in_hold"}, 32'(s_ready), 32'd0);
        if (v.hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                @(posedge clk); #1;
                if (!(m_valid && m_class == v.cls && m_err == v.err && !s_ready)) stable = 1'b0;
            end
            chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        exp_frames++;
        if (v.cls) exp_pos++;
        if (v.err) exp_err++;
        chk({tag, "_released"}, {30'd0, m_valid, s_ready}, 32'b01);
    endtask

    initial begin
        vecs[0] = mk(7, 10, 70, 130, 200, 0, 255, 128, 0, 0, 14'b10_11_00_11_10_01_00, 1'b1, 1'b0, 20);
        vecs[1] = mk(3, 255, 255, 255, 0, 0, 0, 0, 0, 0, 14'h003F, 1'b1, 1'b1, 0);
        vecs[2] = mk(9, 0, 0, 0, 0, 0, 0, 64, 255, 255, 14'b01_00_00_00_00_00_00, 1'b0, 1'b1, 0);
        vecs[3] = mk(7, 63, 63, 63, 63, 63, 63, 63, 0, 0, 14'h0000, 1'b0, 1'b0, 0);
        vecs[4] = mk(7, 63, 64, 127, 128, 191, 192, 255, 0, 0, 14'b11_11_10_10_01_01_00, 1'b1, 1'b0, 0);
        vecs[5] = mk(1, 200, 0, 0, 0, 0, 0, 0, 0, 0, 14'h0003, 1'b0, 1'b1, 0);

        #3;
        chk("reset_outputs", {13'd0, s_ready, m_valid, m_class, m_err, feat_vec}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("s_ready_before_edge", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        chk("s_ready_after_release", 32'(s_ready), 32'd1);

        for (int k = 0; k < 4; k++) run_vector(k, vecs[k]);

        // Reset pulse after four beats of a frame
        send_beats(vecs[0], 4, 1'b0);
        chk("partial_feat_vec", 32'(feat_vec), 32'(14'b11_10_01_00));
        rst_n = 1'b0;
        #1;
        chk("midframe_reset", {13'd0, s_ready, m_valid, m_class, m_err, feat_vec}, 32'd0);
        exp_frames = 0; exp_pos = 0; exp_err = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_vector(4, vecs[4]);
        run_vector(5, vecs[5]);

`ifdef TNN_LOADER_STATS_EN
        chk("stat_frames", 32'(stat_frames), 32'(exp_frames));
        chk("stat_pos", 32'(stat_pos), 32'(exp_pos));
        chk("stat_err", 32'(stat_err), 32'(exp_err));
        force dut.r_stat_frames = 16'hFFFF;
        @(negedge clk);
        release dut.r_stat_frames;
        run_vector(0, vecs[0]);
        chk("stat_frames_saturated", 32'(stat_frames), 32'h0000FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
